// File: rtl/osc_meas_pkg.sv
// Shared definitions for the oscillator frequency meter: FSM state encoding
// and a small elaboration-time helper.
`timescale 1ns / 1ps

package osc_meas_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWarmup  = 2'd1,
        StMeasure = 2'd2,
        StDone    = 2'd3
    } osc_state_e;

    // Larger of two unsigned values, used to size the shared gate counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous oscillator into the clk domain through a
// SYNC_STAGES flip-flop chain, then flags each synchronized rising edge with
// a one-cycle pulse using a single history flop.
`timescale 1ns / 1ps

module osc_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Shift the raw input through the synchronizer and keep one cycle of history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/osc_freq_counter.sv
// Oscillator frequency meter: enables the oscillator, waits SETTLE_CYCLES for
// it to settle, counts synchronized rising edges over GATE_CYCLES clk cycles
// and publishes the count with overflow/stalled flags as a one-cycle-valid
// result. Optionally re-arms back-to-back windows without re-settling.
`timescale 1ns / 1ps

module osc_freq_counter
    import osc_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic             i_osc_in,
    output logic             o_osc_en,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    output logic             o_overflow,
    output logic             o_stalled
);

    // One down-counter times both the settle and the gate window.
    localparam int unsigned GATE_W = $clog2(max_u(GATE_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [GATE_W-1:0] GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    osc_state_e        r_state;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_ovf;
    logic              r_osc_en;
    logic              r_busy;
    logic [CNT_W-1:0]  r_count;
    logic              r_count_valid;
    logic              r_overflow;
    logic              r_stalled;

    logic              w_edge;
    logic [CNT_W-1:0]  w_edge_cnt_nxt;
    logic              w_ovf_nxt;
    logic              w_gate_last;

    osc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_osc_in),
        .o_edge  (w_edge)
    );

    assign w_gate_last = (r_gate_cnt == '0);

    // Saturating edge count including this cycle's edge; overflow latches on a lost increment.
    always_comb begin
        w_edge_cnt_nxt = r_edge_cnt;
        w_ovf_nxt      = r_ovf;
        if (w_edge) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_edge_cnt_nxt = r_edge_cnt + 1'b1;
            end
        end
    end

    // Measurement sequencer with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_gate_cnt    <= '0;
            r_edge_cnt    <= '0;
            r_ovf         <= 1'b0;
            r_osc_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_stalled     <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state    <= StWarmup;
                        r_gate_cnt <= SETTLE_LOAD;
                        r_edge_cnt <= '0;
                        r_ovf      <= 1'b0;
                        r_osc_en   <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                StWarmup: begin
                    // Synchronizer keeps running; edges seen while settling are dropped.
                    r_edge_cnt <= '0;
                    r_ovf      <= 1'b0;
                    if (w_gate_last) begin
                        r_state    <= StMeasure;
                        r_gate_cnt <= GATE_LOAD;
                    end else begin
                        r_gate_cnt <= r_gate_cnt - 1'b1;
                    end
                end
                StMeasure: begin
                    if (w_gate_last) begin
                        // Results are loaded on entry to DONE so they are valid
                        // exactly while count_valid is high.
                        r_state       <= StDone;
                        r_count       <= w_edge_cnt_nxt;
                        r_overflow    <= w_ovf_nxt;
                        r_stalled     <= (w_edge_cnt_nxt == '0);
                        r_count_valid <= 1'b1;
                        r_edge_cnt    <= '0;
                        r_ovf         <= 1'b0;
                    end else begin
                        r_edge_cnt <= w_edge_cnt_nxt;
                        r_ovf      <= w_ovf_nxt;
                        r_gate_cnt <= r_gate_cnt - 1'b1;
                    end
                end
                StDone: begin
                    // Dead cycle: edges here are discarded; start is not sampled.
                    if (i_continuous) begin
                        r_state    <= StMeasure;
                        r_gate_cnt <= GATE_LOAD;
                    end else begin
                        r_state  <= StIdle;
                        r_osc_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_osc_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_osc_en      = r_osc_en;
    assign o_busy        = r_busy;
    assign o_count       = r_count;
    assign o_count_valid = r_count_valid;
    assign o_overflow    = r_overflow;
    assign o_stalled     = r_stalled;

endmodule

// File: tb/tb_osc_freq_counter.sv
// Self-checking bench for osc_freq_counter. The reference model records the
// time of every oscillator rising edge and predicts each result by counting
// the edges that fall inside the gate window seen through the synchronizer.
`timescale 1ns / 1ps

module tb_osc_freq_counter;

    localparam int unsigned G    = 100;
    localparam int unsigned SET  = 16;
    localparam int unsigned CW   = 5;
    localparam int unsigned SS   = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;
    localparam real         TCLK = 10.0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          continuous;
    logic          osc_in;
    logic          osc_en;
    logic          busy;
    logic [CW-1:0] count;
    logic          count_valid;
    logic          overflow;
    logic          stalled;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;

    // Oscillator: edges sit at 0.1 + k*0.25 ns fractions, never on a clk edge.
    realtime       osc_half = 15.25;
    bit            osc_run  = 1'b1;
    logic          osc_int  = 1'b0;
    realtime       rise_q[$];

    always #5 clk = ~clk;

    assign osc_in = osc_int & osc_run;

    initial begin
        #0.1;
        forever begin
            #(osc_half);
            osc_int = ~osc_int;
            if (osc_int && osc_run) rise_q.push_back($realtime);
        end
    end

    osc_freq_counter #(
        .GATE_CYCLES   (G),
        .SETTLE_CYCLES (SET),
        .CNT_W         (CW),
        .SYNC_STAGES   (SS)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_continuous  (continuous),
        .i_osc_in      (osc_in),
        .o_osc_en      (osc_en),
        .o_busy        (busy),
        .o_count       (count),
        .o_count_valid (count_valid),
        .o_overflow    (overflow),
        .o_stalled     (stalled)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $realtime);
        end
    endtask

    // Rising edges strictly inside (lo, hi).
    function automatic int unsigned edges_in(input realtime lo, input realtime hi);
        int unsigned n = 0;
        foreach (rise_q[i]) if (rise_q[i] > lo && rise_q[i] < hi) n++;
        return n;
    endfunction

    // Raise start for the next clk edge; returns the time of the edge where
    // the result should appear.
    task automatic pulse_start(output realtime t_done);
        start  = 1'b1;
        t_done = $realtime + 5.0 + real'(SET + G) * TCLK;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Wait for the result due at t_done and compare it with the edge-time model.
    task automatic expect_result(input realtime t_done, input bit cont, input bit poke_start);
        int unsigned early = 0;
        int unsigned n;
        int unsigned exp_cnt;
        @(negedge clk);
        while ($realtime < t_done) begin
            if (count_valid) early++;
            @(negedge clk);
        end
        n       = edges_in(t_done - real'(G + SS) * TCLK, t_done - real'(SS) * TCLK);
        exp_cnt = (n > CMAX) ? CMAX : n;
        check_eq("early_valid", early, 0);
        check_eq("valid", 32'(count_valid), 1);
        check_eq("count", 32'(count), exp_cnt);
        check_eq("overflow", 32'(overflow), 32'(n > CMAX));
        check_eq("stalled", 32'(stalled), 32'(n == 0));
        check_eq("busy_done", 32'(busy), 1);
        if (poke_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("valid_drop", 32'(count_valid), 0);
        check_eq("osc_en_after", 32'(osc_en), 32'(cont));
        check_eq("busy_after", 32'(busy), 32'(cont));
        if (!cont) begin
            @(negedge clk);
            check_eq("idle_stays", 32'(busy), 0);
        end
    endtask

    task automatic run_single(input bit poke_start);
        realtime t_done;
        pulse_start(t_done);
        check_eq("osc_en_on", 32'(osc_en), 1);
        check_eq("busy_on", 32'(busy), 1);
        expect_result(t_done, 1'b0, poke_start);
    endtask

    initial begin
        realtime t_done;
        int unsigned pulses;

        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;

        // Reset values, and a toggling oscillator alone must not start anything.
        repeat (3) @(negedge clk);
        check_eq("rst_osc_en", 32'(osc_en), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_valid", 32'(count_valid), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_stalled", 32'(stalled), 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || osc_en || count_valid) pulses++;
        end
        check_eq("no_start_idle", pulses, 0);

        // Basic window, ~40 ns period.
        osc_half = 20.25;
        run_single(1'b0);
        // Overflow: ~22.5 ns period gives more than 31 edges.
        osc_half = 11.25;
        run_single(1'b0);
        // Stalled: oscillator held low.
        osc_run = 1'b0;
        run_single(1'b0);
        osc_run = 1'b1;
        // Start during DONE->IDLE must be ignored.
        osc_half = 33.25;
        run_single(1'b1);

        // Randomized single-shot windows.
        for (int k = 0; k < 8; k++) begin
            osc_run  = ($urandom_range(0, 4) != 0);
            osc_half = real'($urandom_range(11, 80)) + 0.25;
            rise_q.delete();
            repeat (3) @(negedge clk);
            run_single(1'b0);
        end

        // Continuous mode: back-to-back windows every G+1 cycles, then drop mid-window.
        osc_run    = 1'b1;
        osc_half   = 17.25;
        continuous = 1'b1;
        pulse_start(t_done);
        expect_result(t_done, 1'b1, 1'b0);
        osc_half = 26.25;
        expect_result(t_done + real'(G + 1) * TCLK, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        continuous = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        expect_result(t_done + real'(2 * (G + 1)) * TCLK, 1'b0, 1'b0);
        pulses = 0;
        repeat (G + SET + 10) begin
            @(negedge clk);
            if (count_valid || busy) pulses++;
        end
        check_eq("cont_final_idle", pulses, 0);

        // Reset in the middle of a measurement window.
        continuous = 1'b1;
        pulse_start(t_done);
        repeat (SET + 50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_osc_en", 32'(osc_en), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_count", 32'(count), 0);
        check_eq("mid_rst_valid", 32'(count_valid), 0);
        check_eq("mid_rst_ovf", 32'(overflow), 0);
        check_eq("mid_rst_stalled", 32'(stalled), 0);
        @(negedge clk);
        rst_n      = 1'b1;
        continuous = 1'b0;
        pulses     = 0;
        repeat (G + SET + 20) begin
            @(negedge clk);
            if (count_valid || busy) pulses++;
        end
        check_eq("post_rst_quiet", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
